sms_rom_writer: RTL

- Sits directly downstream of flash_loader.
- Consumes its byte stream (load_addr, load_write_data, data_valid, load_done) and packs bytes into 16-bit words.
- Buffers the packed words in a small FIFO and writes them to the 16-bit cartridge RAM over a req/ack port.
- Throttles the loader through its valid input and reports when the ROM image is fully committed to RAM.

---
 rtl/sms_loader_pkg.sv | 26 ++
 rtl/sms_word_fifo.sv | 57 +++++
 rtl/sms_rom_writer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sms_loader_pkg.sv
// Shared types for the flash-loader downstream writers: writer FSM states,
// byte-lane masks and the packed RAM word handed between pipeline stages.
package sms_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } writer_state_t;

    localparam logic [1:0] MASK_LO   = 2'b01;
    localparam logic [1:0] MASK_HI   = 2'b10;
    localparam logic [1:0] MASK_FULL = 2'b11;

    // Address field is sized for the widest RAM any writer targets; narrower
    // writers use the low bits only.
    localparam int WORD_ADDR_MAX_W = 32;

    typedef struct packed {
        logic [WORD_ADDR_MAX_W-1:0] addr;
        logic [15:0]                data;
        logic [1:0]                 mask;
    } sms_word_t;

endpackage

// File: rtl/sms_word_fifo.sv
// Synchronous FIFO with one push and one pop per cycle; a push while full is
// accepted only when a pop frees the slot in the same cycle.
module sms_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_free
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_free    = (AW+1)'(DEPTH) - r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/sms_rom_writer.sv
// Packs the flash loader's byte stream into 16-bit words, queues them and
// commits them to cartridge RAM over a req/ack port, throttling the loader.
module sms_rom_writer
    import sms_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 22
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              load_strobe,
    input  logic              load_done,
    output logic              loader_valid,
    output logic              mem_req,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_wmask,
    input  logic              mem_ack,
    output logic              rom_ready,
    output logic [ADDR_W:0]   byte_count,
    output logic              overflow,
    output logic [1:0]        dbg_state
);
    localparam int WA_W  = ADDR_W - 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    writer_state_t   r_state;
    logic            r_hold_valid;
    logic [WA_W-1:0] r_hold_addr;
    logic [15:0]     r_hold_data;
    logic [1:0]      r_hold_mask;
    logic            r_mem_req;
    logic [WA_W-1:0] r_mem_addr;
    logic [15:0]     r_mem_wdata;
    logic [1:0]      r_mem_wmask;
    logic            r_rom_ready;
    logic [ADDR_W:0] r_byte_count;
    logic            r_overflow;

    logic             w_accept;
    logic             w_lane;
    logic [WA_W-1:0]  w_word;
    logic [1:0]       w_lane_mask;
    logic [15:0]      w_lane_data;
    logic [15:0]      w_merge_data;
    logic             w_can_merge;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_free;
    sms_word_t        w_push_word;
    sms_word_t        w_head;
    logic             w_nxt_valid;
    logic [WA_W-1:0]  w_nxt_addr;
    logic [15:0]      w_nxt_data;
    logic [1:0]       w_nxt_mask;
    logic             w_unused_head;

    assign w_accept     = load_strobe && (r_state == ST_IDLE || r_state == ST_LOADING);
    assign w_lane       = load_addr[0];
    assign w_word       = load_addr[ADDR_W-1:1];
    assign w_lane_mask  = w_lane ? MASK_HI : MASK_LO;
    assign w_lane_data  = w_lane ? {load_data, 8'h00} : {8'h00, load_data};
    assign w_merge_data = w_lane ? {load_data, r_hold_data[7:0]} : {r_hold_data[15:8], load_data};
    assign w_can_merge  = r_hold_valid && (r_hold_addr == w_word)
                          && ((r_hold_mask & w_lane_mask) == 2'b00);
    assign w_pop        = r_mem_req && mem_ack;
    assign w_unused_head = &{1'b0, w_head.addr[WORD_ADDR_MAX_W-1:WA_W]};

    always_comb begin
        w_push                     = 1'b0;
        w_push_word                = '0;
        w_push_word.addr[WA_W-1:0] = r_hold_addr;
        w_push_word.data           = r_hold_data;
        w_push_word.mask           = r_hold_mask;
        w_nxt_valid                = r_hold_valid;
        w_nxt_addr                 = r_hold_addr;
        w_nxt_data                 = r_hold_data;
        w_nxt_mask                 = r_hold_mask;
        if (w_accept) begin
            if (w_can_merge) begin
                // A valid holding word has exactly one lane, so a merge always fills it.
                w_push           = 1'b1;
                w_push_word.data = w_merge_data;
                w_push_word.mask = MASK_FULL;
                w_nxt_valid      = 1'b0;
                w_nxt_data       = '0;
                w_nxt_mask       = '0;
            end else begin
                w_push      = r_hold_valid;
                w_nxt_valid = 1'b1;
                w_nxt_addr  = w_word;
                w_nxt_data  = w_lane_data;
                w_nxt_mask  = w_lane_mask;
            end
        end else if (r_state == ST_FLUSH && r_hold_valid) begin
            w_push      = 1'b1;
            w_nxt_valid = 1'b0;
            w_nxt_data  = '0;
            w_nxt_mask  = '0;
        end
    end

    sms_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(sms_word_t))
    ) u_fifo (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_push_word),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_free  (w_free)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_hold_valid <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_data  <= '0;
            r_hold_mask  <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wmask  <= '0;
            r_rom_ready  <= 1'b0;
            r_byte_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_hold_valid <= w_nxt_valid;
            r_hold_addr  <= w_nxt_addr;
            r_hold_data  <= w_nxt_data;
            r_hold_mask  <= w_nxt_mask;
            if (w_accept && r_byte_count != '1) begin
                r_byte_count <= r_byte_count + (ADDR_W+1)'(1);
            end
            if (w_push && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            // After each ack the request rests low for one cycle so the next head settles.
            if (w_pop) begin
                r_mem_req <= 1'b0;
            end else if (!r_mem_req && !w_fifo_empty) begin
                r_mem_req   <= 1'b1;
                r_mem_addr  <= w_head.addr[WA_W-1:0];
                r_mem_wdata <= w_head.data;
                r_mem_wmask <= w_head.mask;
            end
            r_rom_ready <= (r_state == ST_DONE) && load_done;
            case (r_state)
                ST_IDLE:    if (!load_done) r_state <= ST_LOADING;
                ST_LOADING: if (load_done) r_state <= ST_FLUSH;
                ST_FLUSH: begin
                    if (!r_hold_valid && w_fifo_empty && !r_mem_req) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!load_done) begin
                        r_state      <= ST_LOADING;
                        r_byte_count <= '0;
                        r_hold_valid <= 1'b0;
                        r_hold_data  <= '0;
                        r_hold_mask  <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign loader_valid = (r_state == ST_LOADING) && (w_free >= CNT_W'(2));
    assign mem_req      = r_mem_req;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_wmask    = r_mem_wmask;
    assign rom_ready    = r_rom_ready;
    assign byte_count   = r_byte_count;
    assign overflow     = r_overflow;
    assign dbg_state    = r_state;

endmodule
